// File: rtl/game_round_ctrl.sv
// Round sequencer and score datapath (score, high score, round count); all outputs registered, one cycle after the input edge.
// No backpressure; the optional round timer is enabled by defining ROUND_TIMER_EN, otherwise time_left is 0.
module game_round_ctrl #(
  parameter int SCORE_W     = 14,
  parameter int MAX_SCORE   = 9999,
  parameter int ROUND_TICKS = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               pause,
  input  logic               start,
  input  logic [2:0]         hit,
  input  logic               robot_dead,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] h_score,
  output logic [SCORE_W-1:0] rounds,
  output logic [1:0]         state,
  output logic               round_done,
  output logic               new_high,
  output logic [7:0]         time_left
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

  state_t             st_q, st_nxt;
  logic [2:0]         hit_prev;
  logic               start_prev, dead_prev;
  logic [2:0]         hit_rise;
  logic               start_rise, dead_rise;
  logic [1:0]         hit_cnt;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [SCORE_W-1:0] score_nxt, h_nxt, rounds_nxt;
  logic               done_nxt, high_nxt;
  logic               round_start, play_run, round_end, timer_expire;

  assign hit_rise   = hit & ~hit_prev;
  assign start_rise = start & ~start_prev;
  assign dead_rise  = robot_dead & ~dead_prev;

  assign hit_cnt   = {1'b0, hit_rise[0]} + {1'b0, hit_rise[1]} + {1'b0, hit_rise[2]};
  assign score_sum = {1'b0, score} + {{(SCORE_W-1){1'b0}}, hit_cnt};
  assign score_sat = (score_sum > {1'b0, MAX_V}) ? MAX_V : score_sum[SCORE_W-1:0];

  assign round_start = ((st_q == IDLE) || (st_q == OVER)) && start_rise;
  assign play_run    = (st_q == PLAY) && !pause;
  // Timer expiry and robot death in the same cycle collapse into one round end
  assign round_end   = dead_rise || timer_expire;

`ifdef ROUND_TIMER_EN
  localparam logic [7:0] TICKS_INIT = 8'(ROUND_TICKS);
  logic [7:0] time_q;

  assign timer_expire = play_run && tick_1hz && (time_q == 8'd1);
  assign time_left    = time_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q <= '0;
    end else if (round_start) begin
      time_q <= TICKS_INIT;
    end else if (play_run && tick_1hz && (time_q != 8'd0)) begin
      time_q <= time_q - 8'd1;
    end
  end
`else
  localparam int ticks_unused = ROUND_TICKS;
  logic tick_unused;

  assign tick_unused  = tick_1hz;
  assign timer_expire = 1'b0;
  assign time_left    = '0;
`endif

  always_comb begin
    st_nxt     = st_q;
    score_nxt  = score;
    h_nxt      = h_score;
    rounds_nxt = rounds;
    done_nxt   = 1'b0;
    high_nxt   = 1'b0;
    case (st_q)
      IDLE, OVER: begin
        if (start_rise) begin
          st_nxt     = PLAY;
          score_nxt  = '0;
          rounds_nxt = (rounds >= MAX_V) ? MAX_V : rounds + 1'b1;
        end
      end
      PLAY: begin
        // Pause wins over both hits and round end in the same cycle
        if (pause) begin
          st_nxt = PAUSED;
        end else begin
          score_nxt = score_sat;
          if (round_end) begin
            st_nxt   = OVER;
            done_nxt = 1'b1;
            if (score_sat > h_score) begin
              h_nxt    = score_sat;
              high_nxt = 1'b1;
            end
          end
        end
      end
      PAUSED: begin
        if (!pause) st_nxt = PLAY;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      hit_prev   <= '0;
      start_prev <= 1'b0;
      dead_prev  <= 1'b0;
      score      <= '0;
      h_score    <= '0;
      rounds     <= '0;
      round_done <= 1'b0;
      new_high   <= 1'b0;
    end else begin
      st_q       <= st_nxt;
      hit_prev   <= hit;
      start_prev <= start;
      dead_prev  <= robot_dead;
      score      <= score_nxt;
      h_score    <= h_nxt;
      rounds     <= rounds_nxt;
      round_done <= done_nxt;
      new_high   <= high_nxt;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl; expectations follow the timer build when ROUND_TIMER_EN is defined.
module tb_game_round_ctrl;

`ifdef ROUND_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz, pause, start, robot_dead;
  logic [2:0]  hit;
  logic [13:0] score, h_score, rounds;
  logic [1:0]  state;
  logic        round_done, new_high;
  logic [7:0]  time_left;

  int n_tests = 0;
  int n_fail  = 0;

  game_round_ctrl #(.SCORE_W(14), .MAX_SCORE(9999), .ROUND_TICKS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .pause      (pause),
    .start      (start),
    .hit        (hit),
    .robot_dead (robot_dead),
    .score      (score),
    .h_score    (h_score),
    .rounds     (rounds),
    .state      (state),
    .round_done (round_done),
    .new_high   (new_high),
    .time_left  (time_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_hscore"}, int'(h_score), 0);
    check({tag, "_rounds"}, int'(rounds), 0);
    check({tag, "_done"}, int'(round_done), 0);
    check({tag, "_high"}, int'(new_high), 0);
    check({tag, "_time"}, int'(time_left), 0);
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; pause = 1'b0; start = 1'b0; robot_dead = 1'b0; hit = 3'b000;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_hold", int'(state), 0);

    // Round 1 start
    start = 1'b1; tick();
    check("start_state", int'(state), 1);
    check("start_rounds", int'(rounds), 1);
    check("start_score", int'(score), 0);
    check("start_time", int'(time_left), TMR ? 3 : 0);

    // Two simultaneous rises, then a held level
    hit = 3'b101; tick();
    check("hit101", int'(score), 2);
    for (int i = 0; i < 10; i++) tick();
    check("hit_held", int'(score), 2);
    hit = 3'b000; tick();

    // Hits dropped on pause entry and while paused
    pause = 1'b1; hit = 3'b111; tick();
    check("pause_state", int'(state), 2);
    check("pause_score", int'(score), 2);
    tick();
    check("paused_state", int'(state), 2);
    pause = 1'b0; tick();
    check("resume_state", int'(state), 1);
    tick();
    check("resume_score", int'(score), 2);
    hit = 3'b000; tick();

    // robot_dead rising while paused is ignored and not seen later
    pause = 1'b1; tick();
    robot_dead = 1'b1; tick();
    check("dead_paused", int'(state), 2);
    pause = 1'b0; tick();
    tick();
    check("dead_stale", int'(state), 1);
    robot_dead = 1'b0; tick();

    // End round 1 at score 3
    hit = 3'b001; tick();
    check("score3", int'(score), 3);
    hit = 3'b000; robot_dead = 1'b1; tick();
    check("end1_state", int'(state), 3);
    check("end1_done", int'(round_done), 1);
    check("end1_high", int'(new_high), 1);
    check("end1_hscore", int'(h_score), 3);
    tick();
    check("end1_done_off", int'(round_done), 0);
    check("end1_high_off", int'(new_high), 0);
    check("over_held_start", int'(state), 3);
    robot_dead = 1'b0;

    // Round 2: reach 5, then hit and death together -> 6
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("r2_state", int'(state), 1);
    check("r2_rounds", int'(rounds), 2);
    check("r2_score", int'(score), 0);
    start = 1'b0;
    hit = 3'b111; tick();
    hit = 3'b000; tick();
    hit = 3'b011; tick();
    check("r2_score5", int'(score), 5);
    hit = 3'b000; tick();
    hit = 3'b001; robot_dead = 1'b1; start = 1'b1; tick();
    check("r2_end_score", int'(score), 6);
    check("r2_end_hscore", int'(h_score), 6);
    check("r2_end_state", int'(state), 3);
    check("r2_end_done", int'(round_done), 1);
    check("r2_end_high", int'(new_high), 1);
    tick();
    check("r2_done_off", int'(round_done), 0);
    check("r2_high_off", int'(new_high), 0);
    check("r2_start_same_edge", int'(state), 3);
    check("r2_score_held", int'(score), 6);
    hit = 3'b000; robot_dead = 1'b0;

    // Round 3 ties the high score -> no new_high
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("r3_rounds", int'(rounds), 3);
    hit = 3'b111; tick();
    hit = 3'b000; tick();
    hit = 3'b111; tick();
    hit = 3'b000; tick();
    check("r3_score6", int'(score), 6);
    robot_dead = 1'b1; tick();
    check("r3_state", int'(state), 3);
    check("r3_done", int'(round_done), 1);
    check("r3_tie_high", int'(new_high), 0);
    check("r3_hscore", int'(h_score), 6);
    robot_dead = 1'b0;

    // Round 4 climbs to saturation
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("r4_rounds", int'(rounds), 4);
    for (int i = 0; i < 3332; i++) begin
      hit = 3'b111; tick();
      hit = 3'b000; tick();
    end
    check("r4_9996", int'(score), 9996);
    hit = 3'b011; tick();
    check("r4_9998", int'(score), 9998);
    hit = 3'b000; tick();
    hit = 3'b111; tick();
    check("r4_sat", int'(score), 9999);
    hit = 3'b000; tick();
    hit = 3'b001; tick();
    check("r4_sat_hold", int'(score), 9999);
    hit = 3'b000; robot_dead = 1'b1; tick();
    check("r4_hscore", int'(h_score), 9999);
    check("r4_high", int'(new_high), 1);
    robot_dead = 1'b0;

    // Round 5: timer countdown (inert without the timer)
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("r5_rounds", int'(rounds), 5);
    check("r5_time3", int'(time_left), TMR ? 3 : 0);
    tick_1hz = 1'b1; tick(); tick_1hz = 1'b0;
    check("r5_time2", int'(time_left), TMR ? 2 : 0);
    check("r5_state_a", int'(state), 1);
    tick();
    tick_1hz = 1'b1; tick(); tick_1hz = 1'b0;
    check("r5_time1", int'(time_left), TMR ? 1 : 0);
    tick();
    tick_1hz = 1'b1; tick(); tick_1hz = 1'b0;
    check("r5_time0", int'(time_left), 0);
    check("r5_state_end", int'(state), TMR ? 3 : 1);
    check("r5_done", int'(round_done), TMR ? 1 : 0);
    tick();
    check("r5_done_off", int'(round_done), 0);

    // Reset asynchronously in the middle of a round
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("r6_rounds", int'(rounds), TMR ? 6 : 5);
    hit = 3'b111; tick();
    check("r6_score", int'(score), 3);
    check("r6_state", int'(state), 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    rst = 1'b0; start = 1'b0; hit = 3'b000;
    tick();
    check("post_rst_idle", int'(state), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
